gcc_poll_tx: RTL and testbench

- Joybus initiator that drives the 24-bit GameCube poll command plus stop bit onto the open-drain controller line.
- Holds the controller-data receiver armed (its enable input) while transmitting, then releases it so the receiver can count the reply bits.
- Watches the line for the controller's reply and flags a missing controller on timeout.
- Sits between the adapter's poll scheduler and the GC data receiver.

---
 rtl/gcc_poll_tx.sv | 175 +++++++++++++++++
 tb/tb_gcc_poll_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gcc_poll_tx.sv
// Joybus poll initiator: sends the 24-bit GameCube poll word plus stop bit on an
// open-drain line, then waits for the controller's reply or times out.
module gcc_poll_tx #(
  parameter int          CYC_US          = 48,
  parameter logic [23:0] CMD             = 24'h400302,
  parameter int          RESP_TIMEOUT_US = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic rumble,
  input  logic line_in,
  output logic line_oe,
  output logic rx_enable,
  output logic busy,
  output logic done,
  output logic no_ctrl
);

  localparam int TMAX = RESP_TIMEOUT_US * CYC_US;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [15:0]   T1_LAST = 16'(CYC_US - 1);
  localparam logic [15:0]   T3_LAST = 16'(3 * CYC_US - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TMAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    WAIT_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rx_en_q, rx_en_d;
  logic          done_q, done_d;
  logic          no_ctrl_q, no_ctrl_d;
  logic          sync1_q, line_s_q, line_prev_q;

  logic [15:0] cnt_inc;
  logic [15:0] low_last;
  logic [15:0] high_last;
  logic        line_fall;

  // Synchronizer flops preset high so reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      line_s_q    <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= line_in;
      line_s_q    <= sync1_q;
      line_prev_q <= line_s_q;
    end
  end

  assign line_fall = line_prev_q & ~line_s_q;
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // A '1' is short-low/long-high, a '0' the reverse; both total 4 us.
  assign low_last  = shift_q[23] ? T1_LAST : T3_LAST;
  assign high_last = shift_q[23] ? T3_LAST : T1_LAST;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    rx_en_d   = rx_en_q;
    done_d    = 1'b0;
    no_ctrl_d = no_ctrl_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {CMD[23:1], rumble};
          idx_d   = 5'd23;
          cnt_d   = 16'd0;
          rx_en_d = 1'b1;
          state_d = BIT_LOW;
        end
      end

      BIT_LOW: begin
        if (cnt_q >= low_last) begin
          cnt_d   = 16'd0;
          state_d = BIT_HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      BIT_HIGH: begin
        if (cnt_q >= high_last) begin
          cnt_d = 16'd0;
          if (idx_q == 5'd0) begin
            state_d = STOP_LOW;
          end else begin
            idx_d   = idx_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = BIT_LOW;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      STOP_LOW: begin
        if (cnt_q >= T1_LAST) begin
          cnt_d   = 16'd0;
          tcnt_d  = '0;
          // Releasing the receiver together with the line lets it catch the first reply bit.
          rx_en_d = 1'b0;
          state_d = WAIT_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_RESP: begin
        if (line_fall) begin
          done_d    = 1'b1;
          no_ctrl_d = 1'b0;
          state_d   = IDLE;
        end else if (tcnt_q >= TO_LAST) begin
          done_d    = 1'b1;
          no_ctrl_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      rx_en_q   <= 1'b1;
      done_q    <= 1'b0;
      no_ctrl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      rx_en_q   <= rx_en_d;
      done_q    <= done_d;
      no_ctrl_q <= no_ctrl_d;
    end
  end

  // Decoded straight from the state flop so an async reset drops the pull-down at once.
  assign line_oe   = (state_q == BIT_LOW) || (state_q == STOP_LOW);
  assign busy      = (state_q != IDLE);
  assign rx_enable = rx_en_q;
  assign done      = done_q;
  assign no_ctrl   = no_ctrl_q;

endmodule

// File: tb/tb_gcc_poll_tx.sv
// Directed bench for gcc_poll_tx: decodes the driven frame, checks timing,
// reply/timeout handling, start spamming and mid-frame reset.
module tb_gcc_poll_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic start_man, start_spam, rumble, ctrl_low, spam_en;
  logic start, line_in;
  logic line_oe, rx_enable, busy, done, no_ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_gaps = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  // Open-drain line: low when either side pulls.
  assign line_in = ~(line_oe | ctrl_low);
  assign start   = start_man | start_spam;

  gcc_poll_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rumble    (rumble),
    .line_in   (line_in),
    .line_oe   (line_oe),
    .rx_enable (rx_enable),
    .busy      (busy),
    .done      (done),
    .no_ctrl   (no_ctrl)
  );

  always @(negedge clk) begin
    cyc_n++;
    start_spam = spam_en && busy && (cyc_n % 10 == 0);
  end

  typedef struct {
    logic        rum;
    int          reply_at;
    logic [23:0] exp_word;
    logic        exp_nc;
    int          wmin;
    int          wmax;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic meas(input logic val, output int n);
    n = 0;
    while (line_oe === val && n < 1000) begin
      if (!busy) busy_gaps++;
      @(negedge clk);
      n++;
    end
  endtask

  // One full poll: accept, decode 24 bits + stop, then wait for done.
  task automatic run_txn(input logic rum, input int reply_at,
                         output logic [23:0] word, output int bad, output int total,
                         output int wait_n, output logic rx_at_accept);
    int lo, hi, k;
    word = '0; bad = 0; total = 0; wait_n = 0;
    start_man = 1'b1; rumble = rum;
    @(negedge clk);
    start_man = 1'b0; rumble = 1'b0;
    rx_at_accept = rx_enable;
    k = 0;
    while (line_oe !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int b = 0; b < 24; b++) begin
      meas(1'b1, lo);
      meas(1'b0, hi);
      word = {word[22:0], (lo < hi)};
      if (lo + hi != 192 || !(lo == 48 || lo == 144)) bad++;
      total += lo + hi;
    end
    meas(1'b1, lo);
    if (lo != 48) bad++;
    total += lo;
    while (!done && wait_n < 6000) begin
      if (wait_n == reply_at) ctrl_low = 1'b1;
      if (!busy) busy_gaps++;
      @(negedge clk);
      wait_n++;
    end
  endtask

  logic [23:0] word;
  int bad, total, wait_n, quiet;
  logic rx_acc;

  initial begin
    vecs[0] = '{1'b0, -1,   24'h400302, 1'b1, 4800, 4801};
    vecs[1] = '{1'b1, -1,   24'h400303, 1'b1, 4800, 4801};
    vecs[2] = '{1'b0, 480,  24'h400302, 1'b0, 481,  483};
    vecs[3] = '{1'b1, 100,  24'h400303, 1'b0, 101,  103};
    vecs[4] = '{1'b0, 4797, 24'h400302, 1'b0, 4800, 4800};
    vecs[5] = '{1'b1, 4798, 24'h400303, 1'b1, 4800, 4801};

    rst_n = 1'b0; start_man = 1'b0; rumble = 1'b0; ctrl_low = 1'b0; spam_en = 1'b0;
    start_spam = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst line_oe", line_oe, 0);
    chk("rst rx_enable", rx_enable, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst no_ctrl", no_ctrl, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      busy_gaps = 0;
      run_txn(vecs[i].rum, vecs[i].reply_at, word, bad, total, wait_n, rx_acc);
      $display("[TB] txn %0d rumble=%0d word=%06h wait=%0d no_ctrl=%0d", i, vecs[i].rum, word, wait_n, no_ctrl);
      chk("frame word", word, vecs[i].exp_word);
      chk("bit timing errors", bad, 0);
      chk("drive window", total, 4656);
      chk_rng("done latency", wait_n, vecs[i].wmin, vecs[i].wmax);
      chk("no_ctrl", no_ctrl, vecs[i].exp_nc);
      chk("rx_enable at done", rx_enable, 0);
      chk("busy gaps", busy_gaps, 0);
      chk("rx_enable at accept", rx_acc, 1);
      @(negedge clk);
      chk("done one cycle", done, 0);
      ctrl_low = 1'b0;
      repeat (20) @(negedge clk);
      chk("rx_enable held low idle", rx_enable, 0);
      chk("no_ctrl held", no_ctrl, vecs[i].exp_nc);
    end

    // Start spammed every 10 cycles during a frame.
    busy_gaps = 0;
    spam_en = 1'b1;
    run_txn(1'b0, 480, word, bad, total, wait_n, rx_acc);
    spam_en = 1'b0;
    ctrl_low = 1'b0;
    $display("[TB] spam txn word=%06h wait=%0d", word, wait_n);
    chk("spam word", word, 24'h400302);
    chk("spam timing", bad, 0);
    chk("spam busy gaps", busy_gaps, 0);
    quiet = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (line_oe || busy) quiet++;
    end
    chk("spam no queued frame", quiet, 0);

    // Reset during bit 12 low phase.
    start_man = 1'b1;
    @(negedge clk);
    start_man = 1'b0;
    repeat (11 * 192 + 10) @(negedge clk);
    chk("bit12 line_oe before reset", line_oe, 1);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid-frame reset line_oe=%0d busy=%0d rx_enable=%0d", line_oe, busy, rx_enable);
    chk("reset line_oe", line_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset rx_enable", rx_enable, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    busy_gaps = 0;
    run_txn(1'b0, 480, word, bad, total, wait_n, rx_acc);
    ctrl_low = 1'b0;
    $display("[TB] post-reset txn word=%06h wait=%0d", word, wait_n);
    chk("post-reset word", word, 24'h400302);
    chk("post-reset timing", bad, 0);
    chk("post-reset window", total, 4656);
    chk("post-reset no_ctrl", no_ctrl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
